// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: operation codes, FSM states,
// and the mapping from an operation to the way accumulated beats are folded.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CMB_AND  = 2'd0,
        CMB_OR   = 2'd1,
        CMB_XOR  = 2'd2,
        CMB_REPL = 2'd3
    } comb_t;

    // Inverted ops fold with their base operator; the inversion is applied per beat.
    function automatic comb_t comb_class(input op_t op);
        comb_t c;
        case (op)
            OP_AND, OP_NAND, OP_ANDN: c = CMB_AND;
            OP_OR,  OP_NOR:           c = CMB_OR;
            OP_XOR, OP_XNOR:          c = CMB_XOR;
            default:                  c = CMB_REPL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/logic_op.sv
// Purpose: combinational bitwise operator f(op, a, b).
// Latency: none (pure combinational).
// Backpressure: none; the parent owns all flow control.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_ANDN:   y = a & ~b;
            default:   y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// Purpose: bitwise logic unit with per-beat or packet-fold mode and registered flags.
// Latency: 1 cycle from the accepted (last) beat to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;

    op_t              op_sel;
    logic [WIDTH-1:0] f_y;
    logic [WIDTH-1:0] acc_comb;
    logic [WIDTH-1:0] folded;
    logic             is_last;
    logic             fire_in;
    logic             fire_out;

    assign in_ready = !valid_q || out_ready;
    assign fire_in  = in_valid && in_ready;
    assign fire_out = valid_q && out_ready;

    // Mid-packet beats must use the op latched on the first beat.
    assign op_sel = (state_q == ST_ACC) ? op_q : op_t'(op);

    logic_op #(.WIDTH(WIDTH)) u_op (
        .op (op_sel),
        .a  (a),
        .b  (b),
        .y  (f_y)
    );

    always_comb begin
        acc_comb = f_y;
        case (comb_class(op_q))
            CMB_AND: acc_comb = acc_q & f_y;
            CMB_OR:  acc_comb = acc_q | f_y;
            CMB_XOR: acc_comb = acc_q ^ f_y;
            default: acc_comb = f_y;
        endcase
        folded  = (state_q == ST_ACC) ? acc_comb : f_y;
        is_last = (state_q == ST_ACC) ? (in_last || !mode_q) : (!acc_mode || in_last);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = fire_out ? 1'b0 : valid_q;
        if (fire_in) begin
            if (is_last) begin
                data_d  = folded;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end else begin
                acc_d   = folded;
                state_d = ST_ACC;
                if (state_q == ST_IDLE) begin
                    op_d   = op_t'(op);
                    mode_d = acc_mode;
                end
            end
        end
        zero_d   = (data_d == '0);
        ones_d   = &data_d;
        parity_d = ^data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            ones_q   <= ones_d;
            parity_q <= parity_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = parity_q;

endmodule

// File: tb/tb_logic_unit.sv
// Bench for logic_unit: packet-level reference model, per-cycle compare, directed and random traffic.
module tb_logic_unit;

    logic       clk;
    logic       rst;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       acc_mode, in_last, in_valid, out_ready;
    logic       in_ready, out_zero, out_ones, out_parity, out_valid;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit started = 0;

    logic_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .op         (op),
        .acc_mode   (acc_mode),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(500000);
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] f_model(input int o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            0: return x & y;
            1: return x | y;
            2: return x ^ y;
            3: return ~(x & y);
            4: return ~(x | y);
            5: return ~(x ^ y);
            6: return x & ~y;
            default: return x;
        endcase
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] q[$], input int o);
        logic [7:0] r;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (o == 0 || o == 3 || o == 6)  r = r & q[i];
            else if (o == 1 || o == 4)       r = r | q[i];
            else if (o == 2 || o == 5)       r = r ^ q[i];
            else                             r = q[i];
        end
        return r;
    endfunction

    bit         m_valid = 0;
    logic [7:0] m_data  = 8'h00;
    bit         m_in_pkt = 0;
    int         m_op = 0;
    logic [7:0] m_beats[$];

    always @(posedge clk) begin : model
        bit rdy;
        bit take;
        if (rst) begin
            m_valid  = 0;
            m_data   = 8'h00;
            m_in_pkt = 0;
            m_beats.delete();
        end else begin
            rdy  = !m_valid || out_ready;
            take = in_valid && rdy;
            if (m_valid && out_ready) m_valid = 0;
            if (take) begin
                if (!m_in_pkt) begin
                    if (acc_mode && !in_last) begin
                        m_in_pkt = 1;
                        m_op = int'(op);
                        m_beats.delete();
                        m_beats.push_back(f_model(int'(op), a, b));
                    end else begin
                        m_valid = 1;
                        m_data  = f_model(int'(op), a, b);
                    end
                end else begin
                    m_beats.push_back(f_model(m_op, a, b));
                    if (in_last) begin
                        m_valid  = 1;
                        m_data   = fold(m_beats, m_op);
                        m_in_pkt = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) if (!rst && out_valid && out_ready) pops++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("out_data", 64'(out_data), 64'(m_data));
                check("out_zero", 64'(out_zero), 64'(m_data == 8'h00));
                check("out_ones", 64'(out_ones), 64'(&m_data));
                check("out_parity", 64'(out_parity), 64'(^m_data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                        input logic mode, input logic last);
        bit acc;
        a = ta; b = tb_; op = top; acc_mode = mode; in_last = last; in_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = (!m_valid || out_ready);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept required accept within 100 cycles");
        end
    endtask

    task automatic expect_res(input string name, input logic [7:0] lit);
        bit got;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                check({name, "_data"}, 64'(out_data), 64'(lit));
                check({name, "_model"}, 64'(m_data), 64'(lit));
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid required result 0x%0h", name, lit);
        end
    endtask

    logic [7:0] sweep_exp [8] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5, 8'h50, 8'h5A, 8'hA0, 8'hAA};

    initial begin : stim
        int p0;
        rst = 1'b1; a = 0; b = 0; op = 0; acc_mode = 0; in_last = 0; in_valid = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1;

        // reset state with the sink stalled: in_ready must still be 1
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'h00);
        check("rst_out_zero", 64'(out_zero), 64'd1);
        check("rst_out_ones", 64'(out_ones), 64'd0);
        check("rst_out_parity", 64'(out_parity), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("and_data", 64'(out_data), 64'h30);
        check("and_flags", 64'({out_zero, out_ones, out_parity}), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send(8'hAA, 8'h0F, 3'(i), 1'b0, 1'b0);
            expect_res($sformatf("sweep_op%0d", i), sweep_exp[i]);
        end

        // XOR fold of three beats
        p0 = pops;
        send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h02, 8'h00, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("acc_no_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send(8'h04, 8'h00, 3'd2, 1'b1, 1'b1);
        @(negedge clk);
        check("acc_data", 64'(out_data), 64'h07);
        check("acc_parity", 64'(out_parity), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("acc_one_result", 64'(pops - p0), 64'd1);

        // backpressure
        p0 = pops;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
        a = 8'hFF; b = 8'h0F; op = 3'd0; acc_mode = 0; in_last = 0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", 64'(out_data), 64'h36);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
        expect_res("bp_second", 8'h0F);
        check("bp_pop_count", 64'(pops - p0), 64'd2);

        // reset in the middle of an AND packet
        p0 = pops;
        send(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
        send(8'hF0, 8'hFF, 3'd0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_drop_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        check("rst_drop_count", 64'(pops - p0), 64'd0);
        send(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        check("nor_data", 64'(out_data), 64'hFF);
        check("nor_ones", 64'(out_ones), 64'd1);
        @(posedge clk); #1;

        // op changes mid-packet must be ignored
        send(8'hFF, 8'hF0, 3'd0, 1'b1, 1'b0);
        send(8'hFF, 8'h3C, 3'd1, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 3'd1, 1'b0, 1'b1);
        expect_res("opchg", 8'h30);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            acc_mode  = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 2) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 1..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a  input  WIDTH  operand A.
REQ-005 SHALL have port b  input  WIDTH  operand B.
REQ-006 SHALL have port op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A.
REQ-007 SHALL have port acc_mode  input  1  0 = per-beat result; 1 = fold beats up to in_last.
REQ-008 SHALL have port in_last  input  1  marks the final beat of an accumulate packet; ignored when acc_mode = 0.
REQ-009 SHALL have port in_valid  input  1  input beat valid.
REQ-010 SHALL have port in_ready  output  1  the block accepts the beat.
REQ-011 SHALL have port out_data  output  WIDTH  registered result.
REQ-012 SHALL have port out_zero  output  1  out_data == 0.
REQ-013 SHALL have port out_ones  output  1  out_data is all ones.
REQ-014 SHALL have port out_parity  output  1  XOR-reduction of out_data.
REQ-015 SHALL have port out_valid  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-017 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (one output register; pop and push in the same cycle is allowed).
REQ-019 In per-beat mode, an accepted beat SHALL produce out_data = f(op, a, b) with out_valid high on the next cycle (latency 1).
REQ-020 out_data, the flags and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-021 out_zero, out_ones and out_parity SHALL be registered with out_data and derived from the same value.
REQ-022 The FSM SHALL have two states, IDLE and ACC; reset state SHALL be IDLE.
REQ-023 IDLE, accepted beat with acc_mode = 1 and in_last = 0: acc <= f(op, a, b); op and acc_mode SHALL be latched; go to ACC; no output.
REQ-024 ACC, accepted beat: acc <= acc C f(op_latched, a, b), where C is & for AND/NAND/ANDN, | for OR/NOR, ^ for XOR/XNOR, and replace for PASS_A.
REQ-025 In ACC, the op and acc_mode inputs SHALL be ignored until the packet ends.
REQ-026 An accepted in_last beat (IDLE with acc_mode = 1, or ACC) SHALL load the folded value into out_data, set out_valid on the next cycle, and return to IDLE.
REQ-027 A single-beat packet (IDLE, acc_mode = 1, in_last = 1) SHALL behave exactly like per-beat mode.
REQ-028 Non-last beats in ACC SHALL be accepted under the REQ-018 rule but SHALL NOT set out_valid.
REQ-029 All logic SHALL be bitwise; no carries; WIDTH = 1 SHALL be legal.

Reset
REQ-030 With rst high at a clk edge, the block SHALL reset to: out_valid = 0, out_data = 0, out_zero = 1, out_ones = 0, out_parity = 0, acc = 0, state = IDLE.
REQ-031 rst SHALL take priority over any simultaneous handshake.
REQ-032 A reset during ACC SHALL discard the partial packet; no output SHALL be produced for it.
REQ-033 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-034 Package logic_unit_pkg SHALL hold the op_t enum (8 codes), the state_t enum (IDLE, ACC) and a function mapping op to combine class.
REQ-035 The combinational operator f(op, a, b) SHALL be a sub-module logic_op #(WIDTH); all registers SHALL live in logic_unit.

Verification (WIDTH = 8)
REQ-036 Per-beat test: a=0xF0, b=0x3C, op=AND, out_ready=1 -> out_data=0x30 one cycle later; out_zero=0, out_ones=0, out_parity=0.
REQ-037 Op sweep: a=0xAA, b=0x0F over ops 0..7 -> 0x0A, 0xAF, 0xA5, 0xF5, 0x50, 0x5A, 0xA0, 0xAA.
REQ-038 Accumulate test: op=XOR, acc_mode=1, beats (0x01,0x00), (0x02,0x00), (0x04,0x00, last) -> exactly one result, 0x07, out_parity=1.
REQ-039 Backpressure test: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data held; out_ready=1 -> back-to-back results, none lost or duplicated.
REQ-040 Reset test: rst asserted after beat 2 of a 3-beat AND packet -> out_valid stays 0; the next per-beat NOR of 0x00,0x00 gives 0xFF with out_ones=1.
REQ-041 Op-change test: op changed from AND to OR mid-packet -> result uses AND throughout.
